// File: rtl/uart_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_pkg : shared state encoding and default sizing for the UART receiver
// Revision : 1.0
// ---------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_e;

  localparam int DefaultOverSample = 8;
  localparam int DefaultDataBits   = 8;

endpackage
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_rx_sync : two-flop synchroniser for the serial line plus falling-edge detect
// Revision     : 1.0
// ---------------------------------------------------------------------------
module uart_rx_sync
  import uart_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_rx,
  output logic o_rx_s,
  output logic o_rx_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // All flops reset high so an idle line never looks like a start edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_prev <= 1'b1;
    end else begin
      r_meta <= i_rx;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_rx_s    = r_sync;
  assign o_rx_fall = r_prev & ~r_sync;

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_rx : oversampling UART receiver with valid/ready output and error pulses
//           Optional even parity when UART_RX_PARITY_EN is defined.
// Revision: 1.0
// ---------------------------------------------------------------------------
module uart_rx
  import uart_pkg::*;
#(
  parameter int OverSample = DefaultOverSample,
  parameter int DataBits   = DefaultDataBits
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_en,
  input  logic                i_tick,
  input  logic                i_rx,
  output logic [DataBits-1:0] o_data,
  output logic                o_valid,
  input  logic                i_ready,
  output logic                o_frame_err,
  output logic                o_overrun,
`ifdef UART_RX_PARITY_EN
  output logic                o_parity_err,
`endif
  output logic                o_busy
);

  localparam int TCNT_W = $clog2(OverSample);
  localparam int BCNT_W = $clog2(DataBits);

  localparam logic [TCNT_W-1:0] c_tick_half = TCNT_W'(OverSample / 2 - 1);
  localparam logic [TCNT_W-1:0] c_tick_last = TCNT_W'(OverSample - 1);
  localparam logic [BCNT_W-1:0] c_bit_last  = BCNT_W'(DataBits - 1);

  logic w_rx_s;
  logic w_rx_fall;

  uart_rx_sync u_sync (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_rx      (i_rx),
    .o_rx_s    (w_rx_s),
    .o_rx_fall (w_rx_fall)
  );

  rx_state_e           r_state;
  logic [TCNT_W-1:0]   r_tcnt;
  logic [BCNT_W-1:0]   r_bcnt;
  logic [DataBits-1:0] r_shift;
  logic [DataBits-1:0] r_data;
  logic                r_valid;
  logic                r_frame_err;
  logic                r_overrun;
  logic                w_bit_done;
  logic                w_half_done;
  logic                w_par_ok;

  assign w_bit_done  = i_tick && (r_tcnt == c_tick_last);
  assign w_half_done = i_tick && (r_tcnt == c_tick_half);

`ifdef UART_RX_PARITY_EN
  logic r_par_bad;
  logic r_parity_err;
  assign w_par_ok     = ~r_par_bad;
  assign o_parity_err = r_parity_err;
`else
  assign w_par_ok = 1'b1;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_tcnt      <= '0;
      r_bcnt      <= '0;
      r_shift     <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_bad    <= 1'b0;
      r_parity_err <= 1'b0;
`endif
    end else begin
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_parity_err <= 1'b0;
`endif
      // Consumption first; a word loaded below in the same cycle overrides it.
      if (r_valid && i_ready) r_valid <= 1'b0;

      if (!i_en) begin
        r_state <= IDLE;
        r_tcnt  <= '0;
        r_bcnt  <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_rx_fall) begin
              r_state <= START;
              r_tcnt  <= '0;
            end
          end
          START: begin
            if (w_half_done) begin
              r_tcnt  <= '0;
              r_bcnt  <= '0;
              r_state <= w_rx_s ? IDLE : DATA;
            end else if (i_tick) begin
              r_tcnt <= r_tcnt + 1'b1;
            end
          end
          DATA: begin
            if (w_bit_done) begin
              r_tcnt  <= '0;
              r_shift <= {w_rx_s, r_shift[DataBits-1:1]};
              if (r_bcnt == c_bit_last) begin
`ifdef UART_RX_PARITY_EN
                r_state <= PARITY;
`else
                r_state <= STOP;
`endif
              end else begin
                r_bcnt <= r_bcnt + 1'b1;
              end
            end else if (i_tick) begin
              r_tcnt <= r_tcnt + 1'b1;
            end
          end
`ifdef UART_RX_PARITY_EN
          PARITY: begin
            if (w_bit_done) begin
              r_tcnt    <= '0;
              r_par_bad <= ^{r_shift, w_rx_s};
              r_state   <= STOP;
            end else if (i_tick) begin
              r_tcnt <= r_tcnt + 1'b1;
            end
          end
`endif
          STOP: begin
            if (w_bit_done) begin
              r_tcnt  <= '0;
              r_state <= IDLE;
`ifdef UART_RX_PARITY_EN
              r_parity_err <= r_par_bad;
`endif
              if (!w_rx_s) begin
                r_frame_err <= 1'b1;
              end else if (w_par_ok) begin
                if (!r_valid || i_ready) begin
                  r_data  <= r_shift;
                  r_valid <= 1'b1;
                end else begin
                  r_overrun <= 1'b1;
                end
              end
            end else if (i_tick) begin
              r_tcnt <= r_tcnt + 1'b1;
            end
          end
          default: begin
            r_state <= IDLE;
            r_tcnt  <= '0;
          end
        endcase
      end
    end
  end

  assign o_data      = r_data;
  assign o_valid     = r_valid;
  assign o_frame_err = r_frame_err;
  assign o_overrun   = r_overrun;
  assign o_busy      = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_uart_rx : scoreboard bench for uart_rx (OverSample=8, DataBits=8, tick every 4 clks)
// Revision   : 1.0
// ---------------------------------------------------------------------------
module tb_uart_rx;

  localparam int OS       = 8;
  localparam int DB       = 8;
  localparam int TICK_DIV = 4;
  localparam int BIT_CLKS = OS * TICK_DIV;

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic          i_en = 1'b1;
  logic          i_tick = 1'b0;
  logic          i_rx = 1'b1;
  logic          i_ready = 1'b0;
  logic [DB-1:0] o_data;
  logic          o_valid;
  logic          o_frame_err;
  logic          o_overrun;
  logic          o_busy;
`ifdef UART_RX_PARITY_EN
  logic          o_parity_err;
`endif

  uart_rx #(.OverSample(OS), .DataBits(DB)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_en        (i_en),
    .i_tick      (i_tick),
    .i_rx        (i_rx),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_frame_err (o_frame_err),
    .o_overrun   (o_overrun),
`ifdef UART_RX_PARITY_EN
    .o_parity_err(o_parity_err),
`endif
    .o_busy      (o_busy)
  );

  always #5 i_clk = ~i_clk;

  int tick_cnt = 0;
  initial begin
    forever begin
      @(posedge i_clk);
      #1;
      i_tick   = (tick_cnt == TICK_DIV - 1);
      tick_cnt = (tick_cnt + 1) % TICK_DIV;
    end
  end

  int checks = 0;
  int errors = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  logic [DB-1:0] exp_q[$];

  // Scoreboard: every accepted word must match the oldest expected word.
  always @(negedge i_clk) begin
    logic [DB-1:0] exp_w;
    if (o_frame_err) fe_cnt++;
    if (o_overrun) ov_cnt++;
    if (i_rst_n && o_valid && i_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_word: got %02h, expected no word", o_data);
      end else begin
        exp_w = exp_q.pop_front();
        if (o_data !== exp_w) begin
          errors++;
          $display("FAIL word_data: got %02h, expected %02h", o_data, exp_w);
        end
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic b);
    i_rx = b;
    wait_clk(BIT_CLKS);
  endtask

  task automatic send_frame(input logic [DB-1:0] d, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < DB; i++) send_bit(d[i]);
    send_bit(stop);
    i_rx = 1'b1;
  endtask

  task automatic wait_drain(input string name);
    for (int k = 0; k < 4 * BIT_CLKS && exp_q.size() != 0; k++) wait_clk(1);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d words outstanding, expected 0", name, exp_q.size());
    end
  endtask

  task automatic check_counts(input string name, input int fe0, input int ov0,
                              input int fe_exp, input int ov_exp);
    checks++;
    if ((fe_cnt - fe0) !== fe_exp) begin
      errors++;
      $display("FAIL %s_frame_err: got %0d pulses, expected %0d", name, fe_cnt - fe0, fe_exp);
    end
    checks++;
    if ((ov_cnt - ov0) !== ov_exp) begin
      errors++;
      $display("FAIL %s_overrun: got %0d pulses, expected %0d", name, ov_cnt - ov0, ov_exp);
    end
  endtask

  task automatic test_reset;
    i_rst_n = 1'b0;
    wait_clk(3);
    checks++;
    if ({o_data, o_valid, o_frame_err, o_overrun, o_busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got data=%02h v=%b fe=%b ov=%b busy=%b, expected all 0",
               o_data, o_valid, o_frame_err, o_overrun, o_busy);
    end
    i_rst_n = 1'b1;
    wait_clk(BIT_CLKS);
  endtask

  task automatic test_basic;
    logic [DB-1:0] d;
    bit seen;
    int fe0;
    int ov0;
    d   = 8'hA5;
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    i_ready = 1'b0;
    exp_q.push_back(d);
    send_bit(1'b0);
    for (int i = 0; i < DB; i++) send_bit(d[i]);
    i_rx = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < BIT_CLKS && !seen; k++) begin
      wait_clk(1);
      if (!o_busy) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL basic_stop_timeout: busy still 1, expected return to idle");
    end
    // The stop sample and the load share one edge, so valid is up on idle entry.
    checks++;
    if (o_valid !== 1'b1 || o_data !== d) begin
      errors++;
      $display("FAIL basic_latency: got v=%b data=%02h, expected v=1 data=%02h", o_valid, o_data, d);
    end
    wait_clk(BIT_CLKS);
    i_ready = 1'b1;
    wait_drain("basic");
    check_counts("basic", fe0, ov0, 0, 0);
  endtask

  task automatic test_glitch;
    int fe0;
    int ov0;
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    i_ready = 1'b1;
    i_rx = 1'b0;
    wait_clk(2 * TICK_DIV);
    i_rx = 1'b1;
    checks++;
    if (o_busy !== 1'b1) begin
      errors++;
      $display("FAIL glitch_start: got busy=%b, expected 1", o_busy);
    end
    wait_clk(BIT_CLKS);
    checks++;
    if (o_busy !== 1'b0 || o_valid !== 1'b0) begin
      errors++;
      $display("FAIL glitch_reject: got busy=%b v=%b, expected 0 0", o_busy, o_valid);
    end
    check_counts("glitch", fe0, ov0, 0, 0);
  endtask

  task automatic test_frame_err;
    int fe0;
    int ov0;
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    i_ready = 1'b1;
    send_frame(8'h3C, 1'b0);
    wait_clk(2 * BIT_CLKS);
    checks++;
    if (o_valid !== 1'b0) begin
      errors++;
      $display("FAIL frame_err_valid: got v=%b, expected 0", o_valid);
    end
    check_counts("frame_err", fe0, ov0, 1, 0);
  endtask

  task automatic test_overrun;
    int fe0;
    int ov0;
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    i_ready = 1'b0;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    wait_clk(BIT_CLKS);
    checks++;
    if (o_valid !== 1'b1 || o_data !== 8'h11) begin
      errors++;
      $display("FAIL overrun_hold: got v=%b data=%02h, expected v=1 data=11", o_valid, o_data);
    end
    check_counts("overrun", fe0, ov0, 0, 1);
    i_ready = 1'b1;
    wait_drain("overrun");
  endtask

  task automatic test_back_to_back;
    int fe0;
    int ov0;
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    i_ready = 1'b1;
    exp_q.push_back(8'h55);
    exp_q.push_back(8'hAA);
    send_frame(8'h55, 1'b1);
    send_frame(8'hAA, 1'b1);
    wait_drain("back_to_back");
    check_counts("back_to_back", fe0, ov0, 0, 0);
  endtask

  task automatic test_enable;
    logic [DB-1:0] d;
    int fe0;
    int ov0;
    d   = 8'h0F;
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    i_ready = 1'b1;
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(d[i]);
    i_rx = d[3];
    wait_clk(BIT_CLKS / 2);
    checks++;
    if (o_busy !== 1'b1) begin
      errors++;
      $display("FAIL enable_busy_before: got busy=%b, expected 1", o_busy);
    end
    i_en = 1'b0;
    wait_clk(1);
    checks++;
    if (o_busy !== 1'b0) begin
      errors++;
      $display("FAIL enable_drop: got busy=%b, expected 0", o_busy);
    end
    i_rx = 1'b1;
    wait_clk(2 * BIT_CLKS);
    i_en = 1'b1;
    wait_clk(BIT_CLKS);
    exp_q.push_back(d);
    send_frame(d, 1'b1);
    wait_drain("enable");
    check_counts("enable", fe0, ov0, 0, 0);
  endtask

  task automatic test_reset_mid;
    i_ready = 1'b0;
    send_frame(8'h77, 1'b1);
    wait_clk(4);
    checks++;
    if (o_valid !== 1'b1 || o_data !== 8'h77) begin
      errors++;
      $display("FAIL rst_mid_pending: got v=%b data=%02h, expected v=1 data=77", o_valid, o_data);
    end
    send_bit(1'b0);
    send_bit(1'b1);
    i_rx = 1'b0;
    wait_clk(BIT_CLKS / 2);
    #3;
    i_rst_n = 1'b0;
    #1;
    checks++;
    if ({o_data, o_valid, o_frame_err, o_overrun, o_busy} !== '0) begin
      errors++;
      $display("FAIL rst_mid_async: got data=%02h v=%b fe=%b ov=%b busy=%b, expected all 0",
               o_data, o_valid, o_frame_err, o_overrun, o_busy);
    end
    i_rx = 1'b1;
    wait_clk(3);
    i_rst_n = 1'b1;
    i_ready = 1'b1;
    wait_clk(2 * BIT_CLKS);
    checks++;
    if (o_valid !== 1'b0 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_after: got v=%b busy=%b, expected 0 0", o_valid, o_busy);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_back_to_back();
    test_enable();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL final_queue: %0d words outstanding, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Oversampling UART receiver; sits directly downstream of the prescaler and consumes its one-cycle oversample strobe.
- Synchronises the serial line, qualifies the start bit at mid-bit, and shifts in data LSB first.
- Checks the stop bit, then presents each byte on a valid/ready handshake to the host-side FIFO or register interface.
- Reports framing and overrun errors as one-cycle pulses.

Parameters:
- OverSample, 8, i_tick pulses per bit period; even, >= 4.
- DataBits, 8, data bits per frame; 5..9.

Ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  reset; asynchronous, active-low.
- i_en  in  1  receiver enable; low forces IDLE.
- i_tick  in  1  oversample strobe; one i_clk cycle wide, OverSample pulses per bit.
- i_rx  in  1  asynchronous serial input; idles high.
- o_data  out  DataBits  received word, LSB = first bit on the line.
- o_valid  out  1  o_data holds an unconsumed word.
- i_ready  in  1  consumer accepts o_data when o_valid && i_ready.
- o_frame_err  out  1  one-cycle pulse: stop bit sampled low.
- o_overrun  out  1  one-cycle pulse: frame completed while o_valid still high.
- o_busy  out  1  FSM is not in IDLE.

Behaviour:
- Reset values: o_data=0, o_valid=0, o_frame_err=0, o_overrun=0, o_busy=0, FSM=IDLE, synchroniser flops=1.
- Synchroniser: i_rx passes through 2 flops (rx_s). All FSM decisions use rx_s. A falling edge is rx_s low while the previous rx_s was high.
- Tick counter (tcnt): width $clog2(OverSample). Advances only on i_tick. Cleared on every state entry.
- Bit counter (bcnt): counts 0..DataBits-1.
- IDLE:
  - Falling edge -> START; tcnt=0.
- START:
  - On the i_tick where tcnt == OverSample/2-1, sample rx_s.
  - rx_s low -> DATA; tcnt=0, bcnt=0.
  - rx_s high -> IDLE (glitch reject, no error).
- DATA:
  - On the i_tick where tcnt == OverSample-1, sample rx_s into shift register MSB and shift right.
  - Stay until bcnt == DataBits-1 sampled, then -> STOP.
- STOP:
  - On the i_tick where tcnt == OverSample-1, sample rx_s.
  - rx_s high, o_valid=0 or i_ready=1 that cycle: load o_data, set o_valid next cycle.
  - rx_s high, o_valid=1 and i_ready=0: pulse o_overrun; old o_data kept; new word dropped.
  - rx_s low: pulse o_frame_err; word dropped.
  - All three cases -> IDLE.
- Sampling is therefore centred in each bit, because START consumed half a bit period.
- Latency: o_valid rises on the first i_clk edge after the stop-bit sample tick.
- Handshake: o_valid clears the cycle after o_valid && i_ready, unless a new word loads in the same cycle; then o_valid stays 1 with new data.
- i_tick absent: FSM holds state indefinitely.
- i_en low: FSM -> IDLE and counters clear on the next clock.
  - o_valid and o_data are held, so a pending word survives.
  - Error pulses are suppressed while i_en is low.
- Reset mid-frame: asynchronous return to the reset values; the partial word is discarded.
- A falling edge during STOP is ignored. A new start is detected only from IDLE, one clock after STOP exits.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP and samples one bit at tcnt == OverSample-1.
  - Parity is even: XOR of the data bits and the parity bit must be 0.
  - Adds output port o_parity_err (1 bit, reset 0): one-cycle pulse issued together with the STOP decision.
  - A word with bad parity is dropped, even if its stop bit is valid.
- Undefined: no PARITY state and no o_parity_err port. The frame is start + DataBits + stop.

Decomposition:
- uart_pkg holds:
  - typedef enum logic [2:0] rx_state_e {IDLE, START, DATA, PARITY, STOP}.
  - localparam DefaultOverSample = 8.
  - localparam DefaultDataBits = 8.
- Sub-module uart_rx_sync: 2-flop synchroniser plus falling-edge detect. Outputs rx_s and rx_fall; reset value is high.

Test Plan:
- Basic frame: OverSample=8, i_tick every 4 clks, send 0xA5 with stop=1 -> o_valid=1 with o_data=0xA5 one clock after the stop sample; o_frame_err=0.
- Glitch reject: i_rx low for 2 ticks, then high -> FSM returns to IDLE at the mid-start sample; o_valid=0 and no error pulse.
- Framing error: send 0x3C with stop=0 -> single-cycle o_frame_err=1; o_valid stays 0.
- Overrun: send 0x11 with i_ready=0, then 0x22 -> o_overrun pulses once; o_data remains 0x11.
- Back-to-back with handshake: send 0x55 then 0xAA with i_ready=1 -> two o_valid handshakes carrying 0x55 then 0xAA; no errors.
- Reset/enable mid-frame:
  - Drop i_en during bit 3 -> o_busy=0 within 1 clk; the next full frame 0x0F is received correctly.
  - Pulse i_rst_n low mid-frame -> all outputs return to 0 immediately.
